control_unit_p: RTL
===================

# control_unit_p

Parametrised successor of the 8-bit two-state control unit. It fetches 16-bit instructions and holds the 16-entry register file, and it drives the ALU operands, the PC load/increment controls, the data SRAM and the GPIO outputs. It adds configurable data width, multiple output ports, a ready/acknowledge data-memory handshake, latched ALU flags, CALL/RET with a hardware return stack, and HALT. It sits between the PC/instruction ROM, the ALU, the data SRAM and the GPIO pads.

## Interface
- DATA_W, 8: register, ALU and GPIO width (≥8).
- PC_W, 12: program counter width (≥12).
- STACK_DEPTH, 4: return-stack entries (≥1).
- N_OUT, 2: output ports, each DATA_W wide (≥1).
- clk  in  1  clock. One clock; reset is asynchronous and active-low.
- arst_n  in  1  asynchronous active-low reset.
- instruction  in  16  instruction word, valid combinationally during FETCH.
- pc_cur  in  PC_W  current PC value.
- alu_result  in  DATA_W  combinational result of alu_a/alu_b/alu_opcode.
- equal, carry_out  in  1 each  ALU flags for the current operands.
- sram_read_data  in  DATA_W  read data, valid with sram_ack.
- sram_ack  in  1  memory transfer complete.
- in_gpio  in  DATA_W  input port.
- bootstrapping  in  1  IN takes the 8-bit immediate instead of in_gpio.
- alu_opcode  out  3  ALU operation (instruction[14:12]).
- alu_a, alu_b  out  DATA_W each  ALU operands.
- sram_req, sram_write_en  out  1 each  memory request and write strobe.
- sram_addr  out  8  memory address.
- sram_write_data  out  DATA_W  store data.
- pc_load  out  1  combinational; load pc_next at the coming edge.
- pc_next  out  PC_W  combinational jump target.
- pc_inc  out  1  combinational; high in FETCH only.
- out_gpio  out  N_OUT*DATA_W  output ports; port k occupies bits [k*DATA_W +: DATA_W].
- state  out  2  FETCH=0, EXECUTE=1, MEM_WAIT=2, HALT=3.
- stk_err  out  1  sticky return-stack over/underflow.

## Operation
- Instruction fields: op=[15:12], rd=[11:8], ra=[7:4], rb=[3:0], imm8={ra,rb}, imm12={rd,ra,rb}.
- FETCH: latch the instruction fields. Set alu_a=R[ra], alu_b=R[rb], alu_opcode=[14:12]. Go to EXECUTE.
- EXECUTE, decoded by op:
  - 0, rd=0: NOP.
  - 0, rd=1: RET. Pop the stack into pc_next and assert pc_load. If the stack is empty, set stk_err and do not jump.
  - 0, rd=2: HALT. Go to HALT.
  - 0, rd=3: CALL. Push pc_cur, load imm8 zero-extended to PC_W. If the stack is full, set stk_err; no push, no jump.
  - 0, any other rd: NOP.
  - 1: LOAD. Set sram_req=1, sram_write_en=0, sram_addr=imm8. Go to MEM_WAIT.
  - 2: STORE. Same as LOAD but sram_write_en=1 and sram_write_data=R[rd].
  - 3: JMP to imm12 zero-extended.
  - 4: BEQ to imm12 if latched flag Z=1.
  - 5: BC to imm12 if latched flag C=1.
  - 6: IN. R[rd] ← bootstrapping ? zero-extended imm8 : in_gpio.
  - 7: OUT. Port (rb mod N_OUT) ← R[rd]. Other ports hold.
  - 8–F: ALU. R[rd] ← alu_result; Z ← equal; C ← carry_out.
  - Every op except LOAD/STORE/HALT returns to FETCH.
- Only ALU instructions update Z/C. Branches use the latched flags.
- MEM_WAIT: hold sram_req, sram_addr, sram_write_en and sram_write_data stable until sram_ack. On sram_ack, clear sram_req and sram_write_en, and go to FETCH. For LOAD, also write R[rd] ← sram_read_data.
- HALT is absorbing. No PC activity, no memory activity, outputs hold. Only reset exits it.
- Return stack: pointer sp runs 0..STACK_DEPTH. Full when sp=STACK_DEPTH, empty when sp=0. There is no wrap-around.
- stk_err clears only on reset.

## Timing
- Reset (asynchronous): state=FETCH, R[*]=0, Z=C=0, sp=0, stk_err=0. All outputs are 0 except pc_inc=1. alu_*, sram_addr, sram_write_data and out_gpio are all 0.
- Non-memory instructions take 2 cycles (FETCH, EXECUTE).
- LOAD/STORE take 2+N cycles, N≥1 MEM_WAIT cycles. sram_ack is ignored outside MEM_WAIT.
- sram_req rises at the EXECUTE→MEM_WAIT edge. An ack in the first MEM_WAIT cycle gives a 3-cycle instruction.
- pc_load is high only during EXECUTE of a taken JMP/BEQ/BC/CALL/RET. The PC updates at the end of that cycle, so the next FETCH sees the target.
- pc_load and pc_inc are never high together.
- A register written in EXECUTE or MEM_WAIT is visible to the operand read of the immediately following FETCH.
- Reset during MEM_WAIT drops sram_req asynchronously and aborts the transfer.

## Test plan
- Reset mid-STORE, with arst_n low during MEM_WAIT → sram_req=0 immediately. After release: state=0, out_gpio=0.
- bootstrapping=1, IN R1,0x05, IN R2,0x05, then ALU op and BEQ 0x123 → Z=1 and pc_next=0x123 with pc_load for one cycle. Repeat with 0x05/0x06 → no pc_load.
- STORE R1→0x40 with sram_ack after 3 cycles, then LOAD R3←0x40 with read data 0x5A → req held 3 cycles, addr=0x40, data=0x05. After the LOAD, R3=0x5A as seen via OUT.
- CALL 0x20 from pc_cur=0x011, then RET → pc_next=0x020, then 0x011. Five nested CALLs with STACK_DEPTH=4 → fifth ignored, stk_err=1.
- RET with the stack empty → no pc_load, stk_err=1.
- OUT R1 to port 1 with N_OUT=2 → out_gpio[15:8]=R1 and [7:0] unchanged. HALT → state=3, pc_inc=0 indefinitely.

Source files
------------

// File: rtl/control_unit_p.sv
// Two-phase fetch/execute controller with register file, return stack, memory handshake and GPIO.
// Latency: 2 cycles per instruction, or 2+N for LOAD/STORE; the core stalls in MEM_WAIT until sram_ack.
module control_unit_p #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 12,
  parameter int STACK_DEPTH = 4,
  parameter int N_OUT       = 2
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [15:0]             instruction,
  input  logic [PC_W-1:0]         pc_cur,
  input  logic [DATA_W-1:0]       alu_result,
  input  logic                    equal,
  input  logic                    carry_out,
  input  logic [DATA_W-1:0]       sram_read_data,
  input  logic                    sram_ack,
  input  logic [DATA_W-1:0]       in_gpio,
  input  logic                    bootstrapping,
  output logic [2:0]              alu_opcode,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic                    sram_req,
  output logic                    sram_write_en,
  output logic [7:0]              sram_addr,
  output logic [DATA_W-1:0]       sram_write_data,
  output logic                    pc_load,
  output logic [PC_W-1:0]         pc_next,
  output logic                    pc_inc,
  output logic [N_OUT*DATA_W-1:0] out_gpio,
  output logic [1:0]              state,
  output logic                    stk_err
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  state_t             st;
  logic [3:0]         f_op, f_rd, f_ra, f_rb;
  logic [DATA_W-1:0]  regs [16];
  logic [PC_W-1:0]    stk  [2**SP_W];
  logic [SP_W-1:0]    sp;
  logic               flag_z, flag_c;
  logic [7:0]         imm8;
  logic [11:0]        imm12;
  logic               stk_empty, stk_full;

  assign imm8      = {f_ra, f_rb};
  assign imm12     = {f_rd, f_ra, f_rb};
  assign stk_empty = (sp == '0);
  assign stk_full  = (sp == SP_W'(STACK_DEPTH));
  assign state     = st;
  assign pc_inc    = (st == S_FETCH);

  // Jump decision is combinational so the PC can load at the end of EXECUTE.
  always_comb begin
    pc_load = 1'b0;
    pc_next = '0;
    if (st == S_EXEC) begin
      case (f_op)
        4'h0: begin
          if (f_rd == 4'h1 && !stk_empty) begin
            pc_load = 1'b1;
            pc_next = stk[sp - SP_W'(1)];
          end else if (f_rd == 4'h3 && !stk_full) begin
            pc_load = 1'b1;
            pc_next = PC_W'(imm8);
          end
        end
        4'h3: begin
          pc_load = 1'b1;
          pc_next = PC_W'(imm12);
        end
        4'h4: begin
          pc_load = flag_z;
          pc_next = flag_z ? PC_W'(imm12) : '0;
        end
        4'h5: begin
          pc_load = flag_c;
          pc_next = flag_c ? PC_W'(imm12) : '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      st              <= S_FETCH;
      f_op            <= '0;
      f_rd            <= '0;
      f_ra            <= '0;
      f_rb            <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      for (int i = 0; i < 2**SP_W; i++) stk[i] <= '0;
      sp              <= '0;
      flag_z          <= 1'b0;
      flag_c          <= 1'b0;
      stk_err         <= 1'b0;
      alu_opcode      <= '0;
      alu_a           <= '0;
      alu_b           <= '0;
      sram_req        <= 1'b0;
      sram_write_en   <= 1'b0;
      sram_addr       <= '0;
      sram_write_data <= '0;
      out_gpio        <= '0;
    end else begin
      case (st)
        S_FETCH: begin
          f_op       <= instruction[15:12];
          f_rd       <= instruction[11:8];
          f_ra       <= instruction[7:4];
          f_rb       <= instruction[3:0];
          alu_a      <= regs[instruction[7:4]];
          alu_b      <= regs[instruction[3:0]];
          alu_opcode <= instruction[14:12];
          st         <= S_EXEC;
        end
        S_EXEC: begin
          st <= S_FETCH;
          case (f_op)
            4'h0: begin
              case (f_rd)
                4'h1: if (stk_empty) stk_err <= 1'b1;
                      else sp <= sp - SP_W'(1);
                4'h2: st <= S_HALT;
                4'h3: if (stk_full) stk_err <= 1'b1;
                      else begin
                        stk[sp] <= pc_cur;
                        sp      <= sp + SP_W'(1);
                      end
                default: ;
              endcase
            end
            4'h1: begin
              sram_req      <= 1'b1;
              sram_write_en <= 1'b0;
              sram_addr     <= imm8;
              st            <= S_MEM;
            end
            4'h2: begin
              sram_req        <= 1'b1;
              sram_write_en   <= 1'b1;
              sram_addr       <= imm8;
              sram_write_data <= regs[f_rd];
              st              <= S_MEM;
            end
            4'h6: regs[f_rd] <= bootstrapping ? DATA_W'(imm8) : in_gpio;
            4'h7: begin
              for (int k = 0; k < N_OUT; k++)
                if (k == (int'(f_rb) % N_OUT)) out_gpio[k*DATA_W +: DATA_W] <= regs[f_rd];
            end
            default: begin
              if (f_op[3]) begin
                regs[f_rd] <= alu_result;
                flag_z     <= equal;
                flag_c     <= carry_out;
              end
            end
          endcase
        end
        S_MEM: begin
          if (sram_ack) begin
            sram_req      <= 1'b0;
            sram_write_en <= 1'b0;
            if (f_op == 4'h1) regs[f_rd] <= sram_read_data;
            st            <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
